config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 72, giving the number of bits in the downstream configuration chain.
REQ-002 SHALL have parameter WORD_W, default 16, giving the width of each bitstream word.
REQ-003 SHALL have port clk, input, 1 bit: system clock. One clock only; every register updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset. Synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin one full chain load.
REQ-006 SHALL have port word_in, input, WORD_W bits: bitstream word. Bit 0 is shifted first.
REQ-007 SHALL have port word_valid, input, 1 bit: word_in holds a valid word.
REQ-008 SHALL have port word_ready, output, 1 bit: the loader accepts word_in in this cycle.
REQ-009 SHALL have port config_in, output, 1 bit: serial data to the chain head.
REQ-010 SHALL have port config_clk, output, 1 bit: registered chain shift clock.
REQ-011 SHALL have port config_en, output, 1 bit: chain shift enable.
REQ-012 SHALL have port config_out, input, 1 bit: chain tail, used for readback of the previous configuration.
REQ-013 SHALL have port readback_bit, output, 1 bit: captured chain-tail bit.
REQ-014 SHALL have port readback_valid, output, 1 bit: readback_bit is valid (1-cycle pulse).
REQ-015 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-016 SHALL have port done, output, 1 bit: 1-cycle pulse when a load completes.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI and FINISH.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD, clear bit_cnt and set busy=1 from the next cycle.
REQ-019 start SHALL be ignored in all states other than IDLE.
REQ-020 In LOAD, word_ready SHALL be 1 and config_clk 0; word_valid&&word_ready SHALL latch word_in into the shift register and move the FSM to SHIFT_LO.
REQ-021 In LOAD without word_valid, the FSM SHALL stall with config_en held 1 and config_clk held 0. The chain SHALL not be disturbed.
REQ-022 word_ready SHALL be 0 in every state except LOAD.
REQ-023 In SHIFT_LO, outputs SHALL be config_en=1, config_clk=0, config_in=sreg[0].
REQ-024 In SHIFT_HI, outputs SHALL be config_clk=1 with config_in unchanged, then bit_cnt++ and sreg>>=1.
- If bit_cnt==CHAIN_LEN-1: next state FINISH.
- Else if the in-word bit index==WORD_W-1: next state LOAD.
- Else: next state SHIFT_LO.
REQ-025 Each chain bit SHALL therefore take exactly 2 clk cycles (config_clk = clk/2 while shifting).
REQ-026 When CHAIN_LEN is not a multiple of WORD_W, the unused upper bits of the last word SHALL be discarded. The number of words is ceil(CHAIN_LEN/WORD_W): 5 for the defaults.
REQ-027 In FINISH, outputs SHALL be config_en=0, config_clk=0, done=1 for one cycle, busy=0; the FSM then returns to IDLE.
REQ-028 With word_valid held 1, done SHALL assert exactly 2*CHAIN_LEN + NUM_WORDS + 1 cycles after the cycle in which start is sampled (150 for the defaults).
REQ-029 config_out SHALL be sampled at the edge ending each SHIFT_LO cycle, then presented as readback_bit with readback_valid=1 for the following cycle. This gives exactly CHAIN_LEN pulses per load, old chain-tail bit first.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs except word_ready, which is decoded from state.
REQ-031 bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL not wrap within a load.

Reset
REQ-032 rst=1 SHALL force, on the next edge, state=IDLE, and config_en, config_clk, config_in, word_ready, busy, done, readback_valid, readback_bit all 0, and bit_cnt and sreg cleared.
REQ-033 rst asserted mid-load SHALL abort the load immediately, with no done pulse and no further config_clk edges. A later start SHALL restart from chain bit 0.
REQ-034 rst SHALL take priority over start arriving in the same cycle.

Structure
REQ-035 The state enum and default WORD_W/CHAIN_LEN constants SHALL live in the shared package config_pkg.
REQ-036 The FSM, counters and shift register SHALL be one flat module with no sub-modules.

Verification
REQ-037 Verification SHALL cover the default-parameter load: words 0x0000, 0x0118, 0x8C00, 0x0009, 0x0001 with valid always high -> 72 rising config_clk edges, config_in sequence equal to bits 0..71 LSB-first, done at cycle 150, and a connector_box instance downstream holding the pattern.
REQ-038 Verification SHALL cover back-to-back loads with a connector_box attached: the 72 readback bits of load 2 equal the load-1 pattern in shift order.
REQ-039 Verification SHALL cover stall: word_valid low for 7 cycles before word 3 -> config_clk low and config_en high throughout, and done delayed by exactly 7 cycles.
REQ-040 Verification SHALL cover reset mid-shift at bit 40 -> all outputs 0 next cycle, no done, and a subsequent clean load succeeds.
REQ-041 Verification SHALL cover start pulsed while busy -> no effect, and exactly one done pulse per load.
REQ-042 Verification SHALL cover CHAIN_LEN=16, WORD_W=16 -> one word, done at cycle 34, word_ready asserted exactly once.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and default geometry.
package config_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 72;
  localparam int unsigned DEF_WORD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } state_t;

endpackage

// File: rtl/config_loader.sv
// Serialises bitstream words LSB-first into a configuration chain at clk/2,
// capturing the old chain tail as readback while the new pattern shifts in.
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_in,
  output logic              config_clk,
  output logic              config_en,
  input  logic              config_out,
  output logic              readback_bit,
  output logic              readback_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_shr;

  assign sreg_shr   = sreg >> 1;
  assign word_ready = (state == LOAD);

  // Outputs are assigned alongside the transition so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      sreg           <= '0;
      config_in      <= 1'b0;
      config_clk     <= 1'b0;
      config_en      <= 1'b0;
      readback_bit   <= 1'b0;
      readback_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done           <= 1'b0;
      readback_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            config_en  <= 1'b1;
            config_clk <= 1'b0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            sreg      <= word_in;
            bit_idx   <= '0;
            config_in <= word_in[0];
            state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          config_clk     <= 1'b1;
          readback_bit   <= config_out;
          readback_valid <= 1'b1;
          state          <= SHIFT_HI;
        end
        SHIFT_HI: begin
          bit_cnt    <= bit_cnt + CNT_W'(1);
          bit_idx    <= bit_idx + IDX_W'(1);
          sreg       <= sreg_shr;
          config_clk <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state     <= FINISH;
            config_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (bit_idx == LAST_IDX) begin
            state <= LOAD;
          end else begin
            config_in <= sreg_shr[0];
            state     <= SHIFT_LO;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with behavioural chain models and bit-level scoreboards.
module tb_config_loader;
  import config_pkg::*;

  localparam int unsigned CL = 72;
  localparam int unsigned WW = 16;
  localparam int unsigned NW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, word_valid;
  logic [WW-1:0] word_in;
  logic          word_ready, config_in, config_clk, config_en, config_out;
  logic          readback_bit, readback_valid, busy, done;

  logic          start_b, word_valid_b;
  logic [15:0]   word_in_b;
  logic          word_ready_b, config_in_b, config_clk_b, config_en_b, config_out_b;
  logic          readback_bit_b, readback_valid_b, busy_b, done_b;

  logic [CL-1:0] chain   = '0;
  logic [15:0]   chain_b = '0;
  assign config_out   = chain[CL-1];
  assign config_out_b = chain_b[15];

  always @(posedge config_clk)   if (config_en)   chain   <= {chain[CL-2:0], config_in};
  always @(posedge config_clk_b) if (config_en_b) chain_b <= {chain_b[14:0], config_in_b};

  config_loader dut (
    .clk(clk), .rst(rst), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .config_in(config_in), .config_clk(config_clk),
    .config_en(config_en), .config_out(config_out), .readback_bit(readback_bit),
    .readback_valid(readback_valid), .busy(busy), .done(done)
  );

  config_loader #(.CHAIN_LEN(16), .WORD_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .word_in(word_in_b), .word_valid(word_valid_b),
    .word_ready(word_ready_b), .config_in(config_in_b), .config_clk(config_clk_b),
    .config_en(config_en_b), .config_out(config_out_b), .readback_bit(readback_bit_b),
    .readback_valid(readback_valid_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;
  logic exp_q[$];
  logic rb_q[$];
  logic [WW-1:0] words [NW];
  logic [CL-1:0] prev_pat;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] pattern();
    logic [CL-1:0] p;
    for (int i = 0; i < int'(CL); i++) p[i] = words[i / int'(WW)][i % int'(WW)];
    return p;
  endfunction

  task automatic fill_rb(input logic [CL-1:0] p);
    rb_q.delete();
    for (int i = 0; i < int'(CL); i++) rb_q.push_back(p[i]);
  endtask

  // One load on the default instance; abort_bit>0 resets after that many chain clocks.
  task automatic do_load(input int stall_word, input int stall_n, input int busy_start_at,
                         input int abort_bit, input bit rb_check, input int exp_done);
    int cyc, widx, stall_left, rises, dones, rbn, done_at, highs;
    logic prev_clk;
    logic [CL-1:0] rev, p;
    cyc = 0; widx = 0; stall_left = stall_n; rises = 0; dones = 0; rbn = 0;
    done_at = -1; prev_clk = 1'b0;
    exp_q.delete();
    @(negedge clk); start = 1'b1; word_valid = 1'b0;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 400) begin
      if (dones > 0 && cyc >= done_at + 2) break;
      if (config_clk && !prev_clk) begin
        rises++;
        if (exp_q.size() > 0) chk("config_in", 72'(config_in), 72'(exp_q.pop_front()));
        else chk("rise_without_bit", 72'(exp_q.size()), 72'(1));
      end
      prev_clk = config_clk;
      if (word_ready) chk("load_clk_en", 72'({config_clk, config_en}), 72'(2'b01));
      if (readback_valid) begin
        rbn++;
        if (rb_check && rb_q.size() > 0) chk("readback", 72'(readback_bit), 72'(rb_q.pop_front()));
      end
      if (done) begin
        dones++;
        done_at = cyc;
        chk("finish_outs", 72'({busy, config_en, config_clk}), 72'(3'b000));
      end else if (dones == 0) begin
        chk("busy", 72'(busy), 72'(1'b1));
      end
      if (abort_bit > 0 && rises == abort_bit) begin
        rst = 1'b1; word_valid = 1'b0;
        @(negedge clk);
        chk("abort_outs", 72'({config_en, config_clk, config_in, word_ready, busy, done,
                               readback_valid, readback_bit}), 72'(8'h00));
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (done) dones++;
          if (config_clk) highs++;
        end
        chk("abort_no_done", 72'(dones), 72'(0));
        chk("abort_no_clk", 72'(highs), 72'(0));
        chk("abort_idle", 72'({busy, word_ready}), 72'(2'b00));
        exp_q.delete();
        rb_q.delete();
        return;
      end
      start = (cyc == busy_start_at);
      word_in = words[(widx < int'(NW)) ? widx : 0];
      if (word_ready && widx == stall_word && stall_left > 0) begin
        word_valid = 1'b0;
        stall_left--;
      end else begin
        word_valid = 1'b1;
      end
      if (word_ready && word_valid && widx < int'(NW)) begin
        for (int j = 0; j < int'(WW); j++)
          if (widx * int'(WW) + j < int'(CL)) exp_q.push_back(words[widx][j]);
        widx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; word_valid = 1'b0;
    chk("done_cycle", 72'(done_at), 72'(exp_done));
    chk("done_count", 72'(dones), 72'(1));
    chk("clk_rises", 72'(rises), 72'(CL));
    chk("words_taken", 72'(widx), 72'(NW));
    chk("bits_left", 72'(exp_q.size()), 72'(0));
    if (rb_check) chk("readback_count", 72'(rbn), 72'(CL));
    p = pattern();
    for (int i = 0; i < int'(CL); i++) rev[int'(CL) - 1 - i] = p[i];
    chk("chain_contents", 72'(chain), 72'(rev));
  endtask

  initial begin
    int cyc_b, rdy_b, nb, done_at_b;
    logic prev_b;
    logic [15:0] wb, rev_b;

    rst = 1'b1; start = 1'b1; word_valid = 1'b0; word_in = '0;
    start_b = 1'b0; word_valid_b = 1'b0; word_in_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 72'({config_en, config_clk, config_in, word_ready, busy, done,
                           readback_valid, readback_bit}), 72'(8'h00));
    chk("reset_outs_b", 72'({config_en_b, config_clk_b, busy_b, done_b, word_ready_b}), 72'(5'h00));
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 72'({busy, word_ready}), 72'(2'b00));

    // Load 1: reference pattern, chain starts empty
    words[0] = 16'h0000; words[1] = 16'h0118; words[2] = 16'h8C00;
    words[3] = 16'h0009; words[4] = 16'h0001;
    fill_rb('0);
    do_load(-1, 0, -1, 0, 1'b1, 150);
    prev_pat = pattern();

    // Load 2: random words, readback must return load 1; start pulsed just before finish
    for (int i = 0; i < int'(NW); i++) words[i] = 16'($urandom);
    fill_rb(prev_pat);
    do_load(-1, 0, 149, 0, 1'b1, 150);
    prev_pat = pattern();

    // Load 3: seven-cycle stall before word 3, start pulsed mid-load
    words[0] = 16'h0000; words[1] = 16'h0118; words[2] = 16'h8C00;
    words[3] = 16'h0009; words[4] = 16'h0001;
    fill_rb(prev_pat);
    do_load(3, 7, 60, 0, 1'b1, 157);
    prev_pat = pattern();

    // Load 4: aborted by reset at chain bit 40
    for (int i = 0; i < int'(NW); i++) words[i] = 16'($urandom);
    fill_rb(prev_pat);
    do_load(-1, 0, -1, 40, 1'b1, 0);

    // Load 5: clean reload after the abort
    for (int i = 0; i < int'(NW); i++) words[i] = 16'($urandom);
    do_load(-1, 0, -1, 0, 1'b0, 150);

    // Single-word chain on the 16-bit instance
    wb = 16'($urandom) | 16'h8001;
    cyc_b = 0; rdy_b = 0; nb = 0; done_at_b = -1; prev_b = 1'b0;
    @(negedge clk); start_b = 1'b1; word_in_b = wb; word_valid_b = 1'b1;
    @(negedge clk); start_b = 1'b0; cyc_b = 1;
    while (cyc_b < 100) begin
      if (done_at_b >= 0 && cyc_b >= done_at_b + 2) break;
      if (word_ready_b) rdy_b++;
      if (config_clk_b && !prev_b) begin
        if (nb < 16) chk("config_in_b", 72'(config_in_b), 72'(wb[nb]));
        nb++;
      end
      prev_b = config_clk_b;
      if (done_b) done_at_b = cyc_b;
      @(negedge clk);
      cyc_b++;
    end
    word_valid_b = 1'b0;
    chk("done_cycle_b", 72'(done_at_b), 72'(34));
    chk("ready_count_b", 72'(rdy_b), 72'(1));
    chk("clk_rises_b", 72'(nb), 72'(16));
    for (int i = 0; i < 16; i++) rev_b[15 - i] = wb[i];
    chk("chain_contents_b", 72'(chain_b), 72'(rev_b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
